collatz_responder: RTL and testbench
====================================

Name: collatz_responder

Overview:
Synthesizable responder for the arg_stb/arg_ack/res_stb handshake, driven by the test initiator task. Latches an argument, iterates the Collatz map one step per cycle, and reports the step count to reach 1. Results are flagged on timeout (step limit) or arithmetic error. Intended as the real DUT behind the initiator's TIMEOUT watchdog.

Parameters:
W, 32, argument/datapath width in bits
MAX_STEPS, 255, step limit; reaching it without x==1 ends with res_timeout
RES_W, $clog2(MAX_STEPS+1), result width (localparam, derived)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
arg  in  W  argument; sampled only in IDLE when arg_stb=1
arg_stb  in  1  initiator request; held high until res_stb seen, then dropped
arg_ack  out  1  argument accepted; high from acceptance until arg_stb drops
res_stb  out  1  result valid; high in DONE until arg_stb drops
res  out  RES_W  step count; valid while res_stb=1
res_timeout  out  1  step limit hit; valid while res_stb=1
res_err  out  1  arg==0 or 3x+1 overflow; valid while res_stb=1

Behaviour:
- Reset (rst=1 at posedge): state IDLE; arg_ack=0, res_stb=0, res=0, res_timeout=0, res_err=0; internal x=0, cnt=0. Reset overrides everything, including mid-computation.
- States: IDLE, BUSY, DONE.
- IDLE, arg_stb=1 at edge E0: x<=arg, cnt<=0, arg_ack<=1, flags<=0, go BUSY.
  - If arg==0: go directly to DONE with res_err=1, res=0, and arg_ack=1 at the same edge. res_stb=1 at E1.
- BUSY, one step per edge:
  - x==1: go DONE; res<=cnt; res_stb<=1.
  - else if cnt==MAX_STEPS: go DONE; res<=cnt; res_timeout<=1; res_stb<=1.
  - else if x even: x<=x>>1; cnt<=cnt+1.
  - else x odd: compute 3x+1 in W+2 bits.
    - Result > 2^W-1: go DONE; res<=cnt; res_err<=1; res_stb<=1.
    - Otherwise: x<=3x+1; cnt<=cnt+1.
- Latency: argument needing S steps gives res_stb=1 at edge E0+S+2. For arg=1, res_stb rises at E2.
- Priority in BUSY: x==1 check, then cnt==MAX_STEPS, then step/overflow.
- DONE: res, res_timeout, res_err and res_stb are held stable while arg_stb=1. On the edge where arg_stb=0: arg_ack<=0, res_stb<=0, go IDLE. res and flags keep their last values but are don't-care.
- Abort: arg_stb=0 sampled in BUSY → arg_ack<=0, go IDLE; no res_stb pulse.
- No re-acceptance until IDLE is reached. arg_stb held high across DONE→IDLE cannot occur (DONE exits only on arg_stb=0). arg_stb=1 on the first IDLE cycle after exit starts a new transaction.
- arg changes while not in IDLE are ignored.
- cnt never exceeds MAX_STEPS; no wrap.

Decomposition:
- Package collatz_pkg holds:
  - state_e enum {IDLE, BUSY, DONE}
  - default W/MAX_STEPS constants
- Sub-module collatz_step: purely combinational; in x[W]; out next[W], is_one, overflow. Applies shift for even x, 3x+1 for odd x. All state and counting stay in the top.

Test Plan:
- arg=1 → arg_ack at E1, res_stb at E2, res=0, flags 0. Drop arg_stb → arg_ack and res_stb both 0 on next edge.
- arg=6 → res_stb at E10, res=8, flags 0. res stays stable for 5 extra cycles of held arg_stb.
- arg=27, MAX_STEPS=255 → res=111, flags 0. Same with MAX_STEPS=100 → res=100, res_timeout=1, res_stb at E102.
- arg=0 → res_err=1, res=0, res_stb at E1. arg=0xFFFFFFFF (odd, 3x+1 overflows) → res_err=1, res=0, res_stb at E2.
- Abort: arg=27, drop arg_stb at E20 → arg_ack=0 at E21, res_stb never rises. Then arg=6 → res=8 normally.
- Reset mid-BUSY (arg=27, rst at E30) → all outputs 0 next edge, state IDLE. A new arg=1 completes with res=0.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared types and defaults for the Collatz responder slice.
// Holds the FSM state encoding, default sizing and the result-width helper.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_W         = 32;
    localparam int DEFAULT_MAX_STEPS = 255;

    // Bits needed to hold a step count from 0 up to max_steps inclusive.
    function automatic int res_width(input int max_steps);
        return $clog2(max_steps + 1);
    endfunction

endpackage

// File: rtl/collatz_responder_if.sv
// Request/response handshake between an initiator and the Collatz responder.
// The initiator drives arg/arg_stb; the responder answers with ack, strobe and result.
interface collatz_responder_if
    import collatz_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter int MAX_STEPS = DEFAULT_MAX_STEPS
);

    localparam int RES_W = res_width(MAX_STEPS);

    logic [W-1:0]     arg;
    logic             arg_stb;
    logic             arg_ack;
    logic             res_stb;
    logic [RES_W-1:0] res;
    logic             res_timeout;
    logic             res_err;

    modport master (
        output arg,
        output arg_stb,
        input  arg_ack,
        input  res_stb,
        input  res,
        input  res_timeout,
        input  res_err
    );

    modport slave (
        input  arg,
        input  arg_stb,
        output arg_ack,
        output res_stb,
        output res,
        output res_timeout,
        output res_err
    );

endinterface

// File: rtl/collatz_step.sv
// One combinational Collatz step: halve an even value, 3x+1 an odd value.
// The odd path is computed two bits wider so overflow past W bits is visible.
module collatz_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] next,
    output logic         is_one,
    output logic         overflow
);

    logic [W+1:0] triple_plus_one;

    always_comb begin
        triple_plus_one = {2'b00, x} + {1'b0, x, 1'b0} + (W+2)'(1);
        is_one          = (x == W'(1));
        overflow        = x[0] & (triple_plus_one[W+1:W] != 2'b00);
        if (x[0]) begin
            next = triple_plus_one[W-1:0];
        end else begin
            next = {1'b0, x[W-1:1]};
        end
    end

endmodule

// File: rtl/collatz_responder.sv
// Handshake responder that counts Collatz steps from a latched argument down to 1.
// Results carry timeout (step limit) and error (zero argument / 3x+1 overflow) flags.
module collatz_responder
    import collatz_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter int MAX_STEPS = DEFAULT_MAX_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    collatz_responder_if.slave bus
);

    localparam int RES_W = res_width(MAX_STEPS);
    localparam logic [RES_W-1:0] CNT_MAX = RES_W'(MAX_STEPS);

    state_e           state_q, state_d;
    logic [W-1:0]     x_q, x_d;
    logic [RES_W-1:0] cnt_q, cnt_d;
    logic             arg_ack_q, arg_ack_d;
    logic             res_stb_q, res_stb_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             res_timeout_q, res_timeout_d;
    logic             res_err_q, res_err_d;

    logic [W-1:0]     step_next;
    logic             step_is_one;
    logic             step_overflow;

    collatz_step #(
        .W(W)
    ) u_step (
        .x        (x_q),
        .next     (step_next),
        .is_one   (step_is_one),
        .overflow (step_overflow)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        cnt_d         = cnt_q;
        arg_ack_d     = arg_ack_q;
        res_stb_d     = res_stb_q;
        res_d         = res_q;
        res_timeout_d = res_timeout_q;
        res_err_d     = res_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.arg_stb) begin
                    x_d           = bus.arg;
                    cnt_d         = '0;
                    arg_ack_d     = 1'b1;
                    res_d         = '0;
                    res_timeout_d = 1'b0;
                    res_err_d     = 1'b0;
                    // Zero never reaches 1, so it is reported as an error right away.
                    if (bus.arg == '0) begin
                        res_err_d = 1'b1;
                        res_stb_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d   = BUSY;
                    end
                end
            end

            BUSY: begin
                if (!bus.arg_stb) begin
                    arg_ack_d = 1'b0;
                    state_d   = IDLE;
                end else if (step_is_one) begin
                    res_d     = cnt_q;
                    res_stb_d = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    res_d         = cnt_q;
                    res_timeout_d = 1'b1;
                    res_stb_d     = 1'b1;
                    state_d       = DONE;
                end else if (step_overflow) begin
                    res_d     = cnt_q;
                    res_err_d = 1'b1;
                    res_stb_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    x_d   = step_next;
                    cnt_d = cnt_q + RES_W'(1);
                end
            end

            DONE: begin
                if (!bus.arg_stb) begin
                    arg_ack_d = 1'b0;
                    res_stb_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            x_q           <= '0;
            cnt_q         <= '0;
            arg_ack_q     <= 1'b0;
            res_stb_q     <= 1'b0;
            res_q         <= '0;
            res_timeout_q <= 1'b0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            cnt_q         <= cnt_d;
            arg_ack_q     <= arg_ack_d;
            res_stb_q     <= res_stb_d;
            res_q         <= res_d;
            res_timeout_q <= res_timeout_d;
            res_err_q     <= res_err_d;
        end
    end

    assign bus.arg_ack     = arg_ack_q;
    assign bus.res_stb     = res_stb_q;
    assign bus.res         = res_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.res_err     = res_err_q;

endmodule

// File: tb/tb_collatz_responder.sv
// Directed bench for collatz_responder: one DUT at the default step limit and
// one with MAX_STEPS=100 to reach the timeout path.
module tb_collatz_responder;

    logic clk;
    logic rst;
    logic use_b;

    int total;
    int bad;

    logic        o_ack;
    logic        o_stb;
    logic        o_to;
    logic        o_err;
    logic [31:0] o_res;

    collatz_responder_if #(.W(32), .MAX_STEPS(255)) ifa ();
    collatz_responder_if #(.W(32), .MAX_STEPS(100)) ifb ();

    collatz_responder #(.W(32), .MAX_STEPS(255)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    collatz_responder #(.W(32), .MAX_STEPS(100)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe whichever DUT the current test is talking to.
    always_comb begin
        o_ack = use_b ? ifb.arg_ack     : ifa.arg_ack;
        o_stb = use_b ? ifb.res_stb     : ifa.res_stb;
        o_to  = use_b ? ifb.res_timeout : ifa.res_timeout;
        o_err = use_b ? ifb.res_err     : ifa.res_err;
        o_res = use_b ? 32'(ifb.res)    : 32'(ifa.res);
    end

    task automatic drive_req(input logic stb, input logic [31:0] a);
        if (use_b) begin
            ifb.arg_stb = stb;
            ifb.arg     = a;
        end else begin
            ifa.arg_stb = stb;
            ifa.arg     = a;
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Raises arg_stb just after an edge (E0) and counts edges until res_stb; -1 on budget expiry.
    task automatic run_txn(input logic [31:0] a, input int budget,
                           output int edges, output int ack_edge);
        edges    = -1;
        ack_edge = -1;
        drive_req(1'b1, a);
        for (int n = 1; n <= budget; n++) begin
            next_edge();
            if (o_ack === 1'b1 && ack_edge < 0) ack_edge = n;
            if (o_stb === 1'b1) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic drop_stb();
        drive_req(1'b0, 32'd0);
        next_edge();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) next_edge();
        total++; if (ifa.arg_ack !== 1'b0)     begin bad++; $display("[TB] FAIL reset_ack: got %b expected 0", ifa.arg_ack); end
        total++; if (ifa.res_stb !== 1'b0)     begin bad++; $display("[TB] FAIL reset_stb: got %b expected 0", ifa.res_stb); end
        total++; if (ifa.res !== 8'd0)         begin bad++; $display("[TB] FAIL reset_res: got %0d expected 0", ifa.res); end
        total++; if (ifa.res_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %b expected 0", ifa.res_timeout); end
        total++; if (ifa.res_err !== 1'b0)     begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", ifa.res_err); end
        total++; if (ifb.res_stb !== 1'b0)     begin bad++; $display("[TB] FAIL reset_stb_b: got %b expected 0", ifb.res_stb); end
        rst = 1'b0;
        next_edge();
    endtask

    task automatic test_arg_one();
        int edges, ack_edge;
        use_b = 1'b0;
        run_txn(32'd1, 20, edges, ack_edge);
        total++; if (ack_edge != 1)  begin bad++; $display("[TB] FAIL one_ack_edge: got %0d expected 1", ack_edge); end
        total++; if (edges != 2)     begin bad++; $display("[TB] FAIL one_latency: got %0d expected 2", edges); end
        total++; if (o_res !== 32'd0) begin bad++; $display("[TB] FAIL one_res: got %0d expected 0", o_res); end
        total++; if ({o_to, o_err} !== 2'b00) begin bad++; $display("[TB] FAIL one_flags: got %b expected 00", {o_to, o_err}); end
        drop_stb();
        total++; if (o_ack !== 1'b0) begin bad++; $display("[TB] FAIL one_drop_ack: got %b expected 0", o_ack); end
        total++; if (o_stb !== 1'b0) begin bad++; $display("[TB] FAIL one_drop_stb: got %b expected 0", o_stb); end
    endtask

    task automatic test_hold_stable();
        int edges, ack_edge;
        use_b = 1'b0;
        run_txn(32'd6, 40, edges, ack_edge);
        total++; if (edges != 10)     begin bad++; $display("[TB] FAIL six_latency: got %0d expected 10", edges); end
        total++; if (o_res !== 32'd8) begin bad++; $display("[TB] FAIL six_res: got %0d expected 8", o_res); end
        total++; if ({o_to, o_err} !== 2'b00) begin bad++; $display("[TB] FAIL six_flags: got %b expected 00", {o_to, o_err}); end
        for (int i = 0; i < 5; i++) begin
            next_edge();
            total++;
            if (o_stb !== 1'b1 || o_res !== 32'd8) begin
                bad++;
                $display("[TB] FAIL six_hold[%0d]: got stb=%b res=%0d expected stb=1 res=8", i, o_stb, o_res);
            end
        end
        drop_stb();
    endtask

    task automatic test_long_and_timeout();
        int edges, ack_edge;
        use_b = 1'b0;
        run_txn(32'd27, 300, edges, ack_edge);
        total++; if (edges != 113)      begin bad++; $display("[TB] FAIL long_latency: got %0d expected 113", edges); end
        total++; if (o_res !== 32'd111) begin bad++; $display("[TB] FAIL long_res: got %0d expected 111", o_res); end
        total++; if ({o_to, o_err} !== 2'b00) begin bad++; $display("[TB] FAIL long_flags: got %b expected 00", {o_to, o_err}); end
        drop_stb();

        use_b = 1'b1;
        run_txn(32'd27, 300, edges, ack_edge);
        total++; if (edges != 102)      begin bad++; $display("[TB] FAIL timeout_latency: got %0d expected 102", edges); end
        total++; if (o_res !== 32'd100) begin bad++; $display("[TB] FAIL timeout_res: got %0d expected 100", o_res); end
        total++; if (o_to !== 1'b1)     begin bad++; $display("[TB] FAIL timeout_flag: got %b expected 1", o_to); end
        total++; if (o_err !== 1'b0)    begin bad++; $display("[TB] FAIL timeout_err: got %b expected 0", o_err); end
        drop_stb();
        use_b = 1'b0;
    endtask

    task automatic test_errors();
        int edges, ack_edge;
        use_b = 1'b0;
        run_txn(32'd0, 20, edges, ack_edge);
        total++; if (edges != 1)      begin bad++; $display("[TB] FAIL zero_latency: got %0d expected 1", edges); end
        total++; if (ack_edge != 1)   begin bad++; $display("[TB] FAIL zero_ack_edge: got %0d expected 1", ack_edge); end
        total++; if (o_err !== 1'b1)  begin bad++; $display("[TB] FAIL zero_err: got %b expected 1", o_err); end
        total++; if (o_res !== 32'd0) begin bad++; $display("[TB] FAIL zero_res: got %0d expected 0", o_res); end
        drop_stb();

        run_txn(32'hFFFF_FFFF, 20, edges, ack_edge);
        total++; if (edges != 2)      begin bad++; $display("[TB] FAIL ovf_latency: got %0d expected 2", edges); end
        total++; if (o_err !== 1'b1)  begin bad++; $display("[TB] FAIL ovf_err: got %b expected 1", o_err); end
        total++; if (o_res !== 32'd0) begin bad++; $display("[TB] FAIL ovf_res: got %0d expected 0", o_res); end
        total++; if (o_to !== 1'b0)   begin bad++; $display("[TB] FAIL ovf_timeout: got %b expected 0", o_to); end
        drop_stb();
    endtask

    task automatic test_abort();
        int edges, ack_edge;
        logic saw_stb;
        use_b   = 1'b0;
        saw_stb = 1'b0;
        drive_req(1'b1, 32'd27);
        for (int n = 1; n <= 20; n++) begin
            next_edge();
            if (o_stb === 1'b1) saw_stb = 1'b1;
        end
        drive_req(1'b0, 32'd0);
        next_edge();
        total++; if (o_ack !== 1'b0) begin bad++; $display("[TB] FAIL abort_ack: got %b expected 0", o_ack); end
        if (o_stb === 1'b1) saw_stb = 1'b1;
        for (int n = 0; n < 5; n++) begin
            next_edge();
            if (o_stb === 1'b1) saw_stb = 1'b1;
        end
        total++; if (saw_stb !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_stb: got %b expected 0", saw_stb); end

        run_txn(32'd6, 40, edges, ack_edge);
        total++; if (edges != 10)     begin bad++; $display("[TB] FAIL abort_next_latency: got %0d expected 10", edges); end
        total++; if (o_res !== 32'd8) begin bad++; $display("[TB] FAIL abort_next_res: got %0d expected 8", o_res); end
        drop_stb();
    endtask

    task automatic test_reset_mid_busy();
        int edges, ack_edge;
        use_b = 1'b0;
        drive_req(1'b1, 32'd27);
        for (int n = 1; n <= 29; n++) next_edge();
        rst = 1'b1;
        drive_req(1'b0, 32'd0);
        next_edge();
        total++;
        if ({o_ack, o_stb, o_to, o_err} !== 4'b0000 || o_res !== 32'd0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got ack=%b stb=%b to=%b err=%b res=%0d expected all 0",
                     o_ack, o_stb, o_to, o_err, o_res);
        end
        rst = 1'b0;
        next_edge();
        run_txn(32'd1, 20, edges, ack_edge);
        total++; if (edges != 2)      begin bad++; $display("[TB] FAIL midreset_next_latency: got %0d expected 2", edges); end
        total++; if (o_res !== 32'd0) begin bad++; $display("[TB] FAIL midreset_next_res: got %0d expected 0", o_res); end
        drop_stb();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        use_b       = 1'b0;
        rst         = 1'b1;
        ifa.arg     = '0;
        ifa.arg_stb = 1'b0;
        ifb.arg     = '0;
        ifb.arg_stb = 1'b0;

        test_reset();
        test_arg_one();
        test_hold_stable();
        test_long_and_timeout();
        test_errors();
        test_abort();
        test_reset_mid_busy();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
